// File: rtl/fft32_bfly_sched.sv
// Butterfly address/twiddle sequencer for an in-place radix-2 DIT FFT, with a
// write-back delay line that drains between stages. hold freezes everything.
module fft32_bfly_sched #(
    parameter int N_LOG2 = 5,
    parameter int PIPE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [2:0]        stage,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] tw_idx,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b
);

    localparam int              KW     = N_LOG2 - 1;
    localparam logic [KW-1:0]   K_LAST = '1;
    localparam logic [2:0]      S_LAST = 3'(N_LOG2 - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k, k_nxt;
    logic [2:0]        stage_q, stage_nxt;
    logic              rd_vld, rd_vld_nxt;
    logic [N_LOG2-1:0] ra, rb, ra_nxt, rb_nxt;
    logic [KW-1:0]     tw, tw_nxt;
    logic [N_LOG2-1:0] kx, half, pos, a_c;
    logic [PIPE-1:0]   dl_vld;
    logic [N_LOG2-1:0] dl_a [PIPE];
    logic [N_LOG2-1:0] dl_b [PIPE];
    logic              upstream, last_wb;

    // The stage's last write-back is at the tail with nothing behind it.
    always_comb begin
        upstream = 1'b0;
        for (int i = 0; i < PIPE - 1; i++) begin
            upstream = upstream | dl_vld[i];
        end
        last_wb = dl_vld[PIPE-1] & ~upstream;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            stage_q <= '0;
            rd_vld  <= 1'b0;
            ra      <= '0;
            rb      <= '0;
            tw      <= '0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            stage_q <= stage_nxt;
            rd_vld  <= rd_vld_nxt;
            ra      <= ra_nxt;
            rb      <= rb_nxt;
            tw      <= tw_nxt;
        end
    end

    // start is honoured in IDLE even under hold; every other move waits for hold low.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        stage_nxt  = stage_q;
        rd_vld_nxt = rd_vld;
        if (state == IDLE) begin
            if (start) begin
                state_nxt  = ISSUE;
                k_nxt      = '0;
                stage_nxt  = '0;
                rd_vld_nxt = 1'b1;
            end
        end else if (!hold) begin
            case (state)
                ISSUE: begin
                    if (k == K_LAST) begin
                        state_nxt  = DRAIN;
                        rd_vld_nxt = 1'b0;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_wb) begin
                        if (stage_q == S_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt  = ISSUE;
                            stage_nxt  = stage_q + 3'd1;
                            k_nxt      = '0;
                            rd_vld_nxt = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    stage_nxt = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // a = (grp << (s+1)) | pos; bit s of a is always clear, so b = a | half.
    always_comb begin
        kx     = N_LOG2'(k_nxt);
        half   = N_LOG2'(1) << stage_nxt;
        pos    = kx & (half - N_LOG2'(1));
        a_c    = ((kx >> stage_nxt) << (stage_nxt + 3'd1)) | pos;
        ra_nxt = '0;
        rb_nxt = '0;
        tw_nxt = '0;
        if (rd_vld_nxt) begin
            ra_nxt = a_c;
            rb_nxt = a_c | half;
            tw_nxt = KW'(pos << (S_LAST - stage_nxt));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld <= '0;
            for (int i = 0; i < PIPE; i++) begin
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else if (!hold) begin
            dl_vld[0] <= rd_vld;
            dl_a[0]   <= ra;
            dl_b[0]   <= rb;
            for (int i = 1; i < PIPE; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_a[i]   <= dl_a[i-1];
                dl_b[i]   <= dl_b[i-1];
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE) & ~hold;
    assign stage     = stage_q;
    assign rd_en     = rd_vld & ~hold;
    assign rd_addr_a = ra;
    assign rd_addr_b = rb;
    assign tw_idx    = tw;
    assign wr_en     = dl_vld[PIPE-1] & ~hold;
    assign wr_addr_a = dl_a[PIPE-1];
    assign wr_addr_b = dl_b[PIPE-1];

endmodule

// File: tb/tb_fft32_bfly_sched.sv
// Scoreboard bench: expected butterflies queued at start, checked on rd_en/wr_en.
module tb_fft32_bfly_sched;

    localparam int PIPE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, hold = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] stage;
    logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [3:0] tw_idx;

    logic       rst1 = 1'b1, start1 = 1'b0, hold1 = 1'b0;
    logic       busy1, done1, rd_en1, wr_en1;
    logic [2:0] stage1;
    logic [4:0] rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;
    logic [3:0] tw_idx1;

    always #5 clk = ~clk;

    fft32_bfly_sched #(.N_LOG2(5), .PIPE(PIPE)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
        .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_idx(tw_idx), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    fft32_bfly_sched #(.N_LOG2(5), .PIPE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .hold(hold1), .busy(busy1), .done(done1),
        .stage(stage1), .rd_en(rd_en1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1),
        .tw_idx(tw_idx1), .wr_en(wr_en1), .wr_addr_a(wr_addr_a1), .wr_addr_b(wr_addr_b1)
    );

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic [3:0] tw;
        logic [2:0] st;
    } rd_t;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic [2:0] st;
        int         nh;
    } wb_t;

    rd_t  exp_rd[$];
    rd_t  rd_log[$];
    wb_t  wb_q[$];
    int   done_cyc[$];
    logic [9:0] q1[$];

    int   checks = 0, failures = 0;
    int   cyc = 0, nh = 0, rd_cnt = 0, wr_cnt = 0;
    logic prev_done = 1'b0;
    rd_t  e, act;
    wb_t  w;

    // Scoreboard monitor for the PIPE=2 instance.
    always @(negedge clk) begin
        cyc++;
        if (prev_done) begin
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_after_done got=%0b exp=0", busy);
            end
        end
        prev_done = done;
        if (hold) begin
            checks++;
            if (rd_en !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL hold_strobe cyc=%0d rd_en=%0b wr_en=%0b done=%0b exp=0", cyc, rd_en, wr_en, done);
            end
        end else begin
            nh++;
            checks++;
            if (wr_en) begin
                wr_cnt++;
                if (wb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_wr cyc=%0d a=%0d b=%0d", cyc, wr_addr_a, wr_addr_b);
                end else begin
                    w = wb_q.pop_front();
                    if (wr_addr_a !== w.a || wr_addr_b !== w.b || nh - w.nh != PIPE) begin
                        failures++;
                        $display("FAIL writeback cyc=%0d got=(%0d,%0d,dt=%0d) exp=(%0d,%0d,dt=%0d)",
                                 cyc, wr_addr_a, wr_addr_b, nh - w.nh, w.a, w.b, PIPE);
                    end
                end
            end else if (wr_addr_a !== 5'd0 || wr_addr_b !== 5'd0) begin
                failures++;
                $display("FAIL wr_addr_idle cyc=%0d got=(%0d,%0d) exp=(0,0)", cyc, wr_addr_a, wr_addr_b);
            end
            checks++;
            if (rd_en) begin
                rd_cnt++;
                act = '{a: rd_addr_a, b: rd_addr_b, tw: tw_idx, st: stage};
                rd_log.push_back(act);
                if (exp_rd.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rd cyc=%0d a=%0d b=%0d", cyc, rd_addr_a, rd_addr_b);
                end else begin
                    e = exp_rd.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL read cyc=%0d got=(%0d,%0d,%0d,s%0d) exp=(%0d,%0d,%0d,s%0d)",
                                 cyc, act.a, act.b, act.tw, act.st, e.a, e.b, e.tw, e.st);
                    end
                    if (wb_q.size() > 0 && wb_q[0].st != e.st) begin
                        failures++;
                        $display("FAIL stage_overlap cyc=%0d rd_stage=%0d pending_wr_stage=%0d", cyc, e.st, wb_q[0].st);
                    end
                    wb_q.push_back('{a: e.a, b: e.b, st: e.st, nh: nh});
                end
            end else if (rd_addr_a !== 5'd0 || rd_addr_b !== 5'd0 || tw_idx !== 4'd0) begin
                failures++;
                $display("FAIL rd_addr_idle cyc=%0d got=(%0d,%0d,%0d) exp=(0,0,0)", cyc, rd_addr_a, rd_addr_b, tw_idx);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_at_done got=%0b exp=1", busy);
                end
            end
        end
    end

    task automatic push_transform();
        rd_t x;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < 16; k++) begin
                int hf, ps, gp;
                hf = 1 << s;
                ps = k % hf;
                gp = k / hf;
                x.a  = 5'(gp * 2 * hf + ps);
                x.b  = 5'(gp * 2 * hf + ps + hf);
                x.tw = 4'(ps * (16 / hf));
                x.st = 3'(s);
                exp_rd.push_back(x);
            end
        end
    endtask

    // Callers are always just past a rising edge.
    task automatic start_run(output int c0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc + 1;
    endtask

    task automatic goto_cycle(input int target);
        for (int i = 0; i < 1000 && cyc + 1 < target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_stats();
        done_cyc.delete();
        rd_log.delete();
        rd_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({busy, done, stage, rd_en, wr_en} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {busy, done, stage, rd_en, wr_en});
        end
        checks++;
        if ({rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b} !== 24'd0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", {rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b});
        end
        checks++;
        if ({busy1, done1, rd_en1, wr_en1, rd_addr_a1, wr_addr_a1} !== 14'd0) begin
            failures++;
            $display("FAIL reset_pipe1 got=%h exp=0", {busy1, done1, rd_en1, wr_en1, rd_addr_a1, wr_addr_a1});
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        rst1 = 1'b0;
    endtask

    task automatic check_run(input string name, input int c0, input int exp_done);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] - c0 != exp_done) begin
            failures++;
            $display("FAIL %s_done count=%0d cycle=%0d exp_count=1 exp_cycle=%0d", name, done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1, exp_done);
        end
        checks++;
        if (rd_cnt != 80 || wr_cnt != 80 || exp_rd.size() != 0 || wb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_counts rd=%0d wr=%0d left=%0d/%0d exp=80/80/0/0", name, rd_cnt, wr_cnt, exp_rd.size(), wb_q.size());
        end
    endtask

    task automatic test_nominal();
        int c0;
        clear_stats();
        push_transform();
        start_run(c0);
        goto_cycle(c0 + 100);
        check_run("nominal", c0, 90);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL nominal_idle busy=%0b exp=0", busy);
        end
        checks++;
        if (rd_log.size() < 80) begin
            failures++;
            $display("FAIL nominal_log size=%0d exp=80", rd_log.size());
        end else begin
            if (rd_log[0].a !== 5'd0 || rd_log[0].b !== 5'd1 || rd_log[0].tw !== 4'd0) begin
                failures++;
                $display("FAIL s0k0 got=(%0d,%0d,%0d) exp=(0,1,0)", rd_log[0].a, rd_log[0].b, rd_log[0].tw);
            end
            checks++;
            if (rd_log[1].a !== 5'd2 || rd_log[1].b !== 5'd3 || rd_log[1].tw !== 4'd0) begin
                failures++;
                $display("FAIL s0k1 got=(%0d,%0d,%0d) exp=(2,3,0)", rd_log[1].a, rd_log[1].b, rd_log[1].tw);
            end
            checks++;
            if (rd_log[19].a !== 5'd5 || rd_log[19].b !== 5'd7 || rd_log[19].tw !== 4'd8) begin
                failures++;
                $display("FAIL s1k3 got=(%0d,%0d,%0d) exp=(5,7,8)", rd_log[19].a, rd_log[19].b, rd_log[19].tw);
            end
            checks++;
            if (rd_log[65].a !== 5'd1 || rd_log[65].b !== 5'd17 || rd_log[65].tw !== 4'd1) begin
                failures++;
                $display("FAIL s4k1 got=(%0d,%0d,%0d) exp=(1,17,1)", rd_log[65].a, rd_log[65].b, rd_log[65].tw);
            end
        end
    endtask

    task automatic test_hold();
        int c0;
        clear_stats();
        push_transform();
        start_run(c0);
        goto_cycle(c0 + 10);
        hold = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        hold = 1'b0;
        goto_cycle(c0 + 55);
        hold = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        hold = 1'b0;
        goto_cycle(c0 + 105);
        check_run("hold", c0, 95);
    endtask

    task automatic test_start_ignored();
        int c0;
        clear_stats();
        push_transform();
        start_run(c0);
        goto_cycle(c0 + 5);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        goto_cycle(c0 + 50);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        goto_cycle(c0 + 100);
        check_run("ignored", c0, 90);
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        clear_stats();
        push_transform();
        push_transform();
        start_run(c0);
        goto_cycle(c0 + 91);
        start_run(c1);
        goto_cycle(c1 + 100);
        checks++;
        if (done_cyc.size() != 2 || done_cyc[0] - c0 != 90 || done_cyc[done_cyc.size()-1] - c1 != 90 || c1 - c0 != 92) begin
            failures++;
            $display("FAIL b2b_done count=%0d restart=%0d exp_count=2 exp_restart=92", done_cyc.size(), c1 - c0);
        end
        checks++;
        if (rd_cnt != 160 || wr_cnt != 160) begin
            failures++;
            $display("FAIL b2b_counts rd=%0d wr=%0d exp=160/160", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        int c0, wr_before;
        clear_stats();
        push_transform();
        start_run(c0);
        goto_cycle(c0 + 40);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd.delete();
        wb_q.delete();
        wr_before = wr_cnt;
        @(negedge clk);
        checks++;
        if ({busy, done, stage, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b} !== 31'd0) begin
            failures++;
            $display("FAIL midrun_reset got=%h exp=0",
                     {busy, done, stage, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b});
        end
        @(posedge clk); #1;
        repeat (30) begin @(posedge clk); #1; end
        checks++;
        if (done_cyc.size() != 0 || wr_cnt != wr_before) begin
            failures++;
            $display("FAIL midrun_quiet done=%0d extra_wr=%0d exp=0/0", done_cyc.size(), wr_cnt - wr_before);
        end
        clear_stats();
        push_transform();
        start_run(c0);
        goto_cycle(c0 + 100);
        check_run("after_reset", c0, 90);
    endtask

    task automatic test_pipe1();
        int nrd, nwr, dc;
        logic [9:0] x;
        nrd = 0; nwr = 0; dc = -1;
        q1.delete();
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wr_en1) begin
                nwr++;
                checks++;
                x = (q1.size() > 0) ? q1.pop_front() : 10'h3ff;
                if ({wr_addr_a1, wr_addr_b1} !== x) begin
                    failures++;
                    $display("FAIL pipe1_wb c=%0d got=%h exp=%h", c, {wr_addr_a1, wr_addr_b1}, x);
                end
            end
            if (rd_en1) begin
                nrd++;
                q1.push_back({rd_addr_a1, rd_addr_b1});
            end
            if (c == 16 || c == 17) begin
                checks++;
                if (rd_en1 !== (c == 17) || (c == 17 && stage1 !== 3'd1)) begin
                    failures++;
                    $display("FAIL pipe1_period c=%0d rd_en=%0b stage=%0d exp_rd_en=%0b", c, rd_en1, stage1, c == 17);
                end
            end
            if (done1 && dc < 0) dc = c;
        end
        @(posedge clk); #1;
        checks++;
        if (dc != 85 || nrd != 80 || nwr != 80) begin
            failures++;
            $display("FAIL pipe1_run done=%0d rd=%0d wr=%0d exp=85/80/80", dc, nrd, nwr);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hold();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        test_pipe1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
